dds_phase_gen: RTL and testbench



---
 rtl/dds_phase_gen.sv | 197 +++++++++++++++++++
 tb/tb_dds_phase_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// ---------------------------------------------------------------------------
// dds_phase_gen
//
// Phase-accumulator front end (NCO) for the DDS sine/cosine core. It produces
// the phase word and a one-cycle phase strobe. The tuning word, phase offset
// and sample-rate divider arrive through a valid/ready config handshake. They
// are held in shadow registers and applied only at sample boundaries, so the
// DDS never sees a half-updated configuration.
//
// Build option:
//   DDS_PHASE_SWEEP_EN - when defined, adds step_i (two's complement). On
//                        every tick the active tuning word advances by the
//                        active step, which produces a linear chirp.
//                        Re-entering RUN restores the last configured tuning
//                        word.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   en_i           run enable (level)
//   cfg_valid_i    config word valid
//   cfg_ready_o    config can be accepted (no config pending)
//   ftw_i          frequency tuning word (unsigned)
//   poff_i         phase offset (unsigned)
//   div_i          strobe divider; one sample every div_i+1 cycles
//   step_i         tuning word step per tick (only with DDS_PHASE_SWEEP_EN)
//   phase_o        phase word to DDS
//   phase_valid_o  one-cycle phase strobe to DDS
//   wrap_o         accumulator carry-out, aligned with phase_valid_o
// ---------------------------------------------------------------------------
module dds_phase_gen #(
   parameter int PHASE_W = 25,
   parameter int DIV_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               en_i,
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   input  logic [PHASE_W-1:0] ftw_i,
   input  logic [PHASE_W-1:0] poff_i,
   input  logic [DIV_W-1:0]   div_i,
`ifdef DDS_PHASE_SWEEP_EN
   input  logic [PHASE_W-1:0] step_i,
`endif
   output logic [PHASE_W-1:0] phase_o,
   output logic               phase_valid_o,
   output logic               wrap_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [0:0]         state_reg;
   logic [PHASE_W-1:0] acc_reg;
   logic [DIV_W-1:0]   div_cnt_reg;

   // Shadow (accepted, not yet applied) configuration
   logic [PHASE_W-1:0] shd_ftw_reg;
   logic [PHASE_W-1:0] shd_poff_reg;
   logic [DIV_W-1:0]   shd_div_reg;
   logic               pending_reg;

   // Active configuration
   logic [PHASE_W-1:0] ftw_act_reg;
   logic [PHASE_W-1:0] ftw_act_next;
   logic [PHASE_W-1:0] poff_act_reg;
   logic [DIV_W-1:0]   div_act_reg;

`ifdef DDS_PHASE_SWEEP_EN
   logic [PHASE_W-1:0] shd_step_reg;
   logic [PHASE_W-1:0] step_act_reg;
   // Last configured tuning word; restored when RUN is re-entered
   logic [PHASE_W-1:0] ftw_cfg_reg;
   logic [PHASE_W-1:0] step_base;
   logic [PHASE_W-1:0] ftw_base;
`endif

   logic [PHASE_W-1:0] phase_reg;
   logic               phase_valid_reg;
   logic               wrap_reg;

   logic               accept;
   logic               tick;
   logic               apply;
   logic [PHASE_W:0]   acc_sum;
   logic [PHASE_W-1:0] phase_sum;

   assign cfg_ready_o = !pending_reg;
   assign accept      = cfg_valid_i && !pending_reg;
   assign tick        = (state_reg == RUN) && en_i && (div_cnt_reg == div_act_reg);
   // In IDLE a pending config goes live at once; in RUN only on a tick,
   // and that tick still uses the old values.
   assign apply       = pending_reg && ((state_reg == IDLE) || tick);

   // Extra top bit captures the accumulator carry. The offset addition
   // wraps silently and never drives wrap_o.
   assign acc_sum   = {1'b0, acc_reg} + {1'b0, ftw_act_reg};
   assign phase_sum = acc_reg + poff_act_reg;

   always_comb begin
      ftw_act_next = ftw_act_reg;
`ifdef DDS_PHASE_SWEEP_EN
      ftw_base  = apply ? shd_ftw_reg  : ftw_act_reg;
      step_base = apply ? shd_step_reg : step_act_reg;
      if (tick) begin
         // The step is applied on top of any config applied on this tick
         ftw_act_next = ftw_base + step_base;
      end else if (apply) begin
         ftw_act_next = shd_ftw_reg;
      end else if (state_reg == IDLE) begin
         ftw_act_next = ftw_cfg_reg;
      end
`else
      if (apply) begin
         ftw_act_next = shd_ftw_reg;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg       <= IDLE;
         acc_reg         <= '0;
         div_cnt_reg     <= '0;
         shd_ftw_reg     <= '0;
         shd_poff_reg    <= '0;
         shd_div_reg     <= '0;
         pending_reg     <= 1'b0;
         ftw_act_reg     <= '0;
         poff_act_reg    <= '0;
         div_act_reg     <= '0;
         phase_reg       <= '0;
         phase_valid_reg <= 1'b0;
         wrap_reg        <= 1'b0;
`ifdef DDS_PHASE_SWEEP_EN
         shd_step_reg    <= '0;
         step_act_reg    <= '0;
         ftw_cfg_reg     <= '0;
`endif
      end else begin
         phase_valid_reg <= 1'b0;
         wrap_reg        <= 1'b0;
         ftw_act_reg     <= ftw_act_next;

         // accept and apply are mutually exclusive: accept needs !pending,
         // apply needs pending.
         if (accept) begin
            shd_ftw_reg  <= ftw_i;
            shd_poff_reg <= poff_i;
            shd_div_reg  <= div_i;
`ifdef DDS_PHASE_SWEEP_EN
            shd_step_reg <= step_i;
`endif
            pending_reg  <= 1'b1;
         end

         if (apply) begin
            poff_act_reg <= shd_poff_reg;
            div_act_reg  <= shd_div_reg;
`ifdef DDS_PHASE_SWEEP_EN
            step_act_reg <= shd_step_reg;
            ftw_cfg_reg  <= shd_ftw_reg;
`endif
            pending_reg  <= 1'b0;
         end

         if (state_reg == IDLE) begin
            acc_reg     <= '0;
            div_cnt_reg <= '0;
            if (en_i) begin
               state_reg <= RUN;
            end
         end else begin
            if (!en_i) begin
               // Leaving RUN: no tick in this cycle
               state_reg <= IDLE;
            end else if (tick) begin
               div_cnt_reg     <= '0;
               phase_reg       <= phase_sum;
               acc_reg         <= acc_sum[PHASE_W-1:0];
               wrap_reg        <= acc_sum[PHASE_W];
               phase_valid_reg <= 1'b1;
            end else begin
               div_cnt_reg <= div_cnt_reg + DIV_ONE;
            end
         end
      end
   end

   assign phase_o       = phase_reg;
   assign phase_valid_o = phase_valid_reg;
   assign wrap_o        = wrap_reg;

endmodule

// File: tb/tb_dds_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_phase_gen
//
// Scoreboard bench for dds_phase_gen. The stimulus process pushes the
// expected phase, wrap and strobe cycle of every sample. A monitor on the
// falling edge pops and compares each phase_valid_o strobe. Handshake and
// reset behaviour are compared directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_dds_phase_gen;
   localparam int PW = 25;
   localparam int DW = 8;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          en_i;
   logic          cfg_valid_i;
   logic          cfg_ready_o;
   logic [PW-1:0] ftw_i;
   logic [PW-1:0] poff_i;
   logic [DW-1:0] div_i;
   logic [PW-1:0] step_i;
   logic [PW-1:0] phase_o;
   logic          phase_valid_o;
   logic          wrap_o;

   dds_phase_gen #(.PHASE_W(PW), .DIV_W(DW)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .en_i         (en_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .ftw_i        (ftw_i),
      .poff_i       (poff_i),
      .div_i        (div_i),
`ifdef DDS_PHASE_SWEEP_EN
      .step_i       (step_i),
`endif
      .phase_o      (phase_o),
      .phase_valid_o(phase_valid_o),
      .wrap_o       (wrap_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [PW-1:0] phase;
      logic          wrap;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_w(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end else begin
         $display("ok   %s = %b", name, act);
      end
   endtask

   task automatic push(input logic [PW-1:0] ph, input logic wr, input int c);
      exp_t e;
      e.phase = ph;
      e.wrap  = wr;
      e.cyc   = c;
      sb.push_back(e);
   endtask

   // Monitor: one line per strobe
   always @(negedge clk_i) begin
      if (phase_valid_o === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got phase 0x%0h at cyc %0d, expected no strobe", phase_o, cyc);
         end else begin
            got = sb.pop_front();
            if (phase_o !== got.phase || wrap_o !== got.wrap || cyc != got.cyc) begin
               n_fail++;
               $display("FAIL strobe: got phase 0x%0h wrap %b cyc %0d, expected phase 0x%0h wrap %b cyc %0d",
                        phase_o, wrap_o, cyc, got.phase, got.wrap, got.cyc);
            end else begin
               $display("ok   strobe cyc %0d phase 0x%0h wrap %b", cyc, phase_o, wrap_o);
            end
         end
      end else if (cyc > 0 && wrap_o !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL wrap_no_strobe: got wrap %b at cyc %0d, expected 0", wrap_o, cyc);
      end
   end

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) cycle();
   endtask

   // Config load in IDLE: accepted at the next edge, applied one edge later
   task automatic do_cfg(input logic [PW-1:0] f, input logic [PW-1:0] p,
                         input logic [DW-1:0] d, input logic [PW-1:0] st);
      cfg_valid_i = 1'b1;
      ftw_i  = f;
      poff_i = p;
      div_i  = d;
      step_i = st;
      check_b("cfg_ready_idle", cfg_ready_o, 1'b1);
      cycle();
      cfg_valid_i = 1'b0;
      check_b("cfg_ready_pending", cfg_ready_o, 1'b0);
      cycle();
      check_b("cfg_ready_applied", cfg_ready_o, 1'b1);
      cycle();
   endtask

   // Run n samples from IDLE; expected values from a plain accumulator model
   task automatic burst(input int n, input logic [PW-1:0] f, input logic [PW-1:0] p,
                        input int d, input logic [PW-1:0] st);
      logic [PW:0]   full;
      logic [PW-1:0] acc;
      logic [PW-1:0] fm;
      int            s;
      acc = '0;
      fm  = f;
      s   = cyc + 2 + d;
      for (int k = 0; k < n; k++) begin
         full = {1'b0, acc} + {1'b0, fm};
         push(acc + p, full[PW], s + k * (d + 1));
         acc = full[PW-1:0];
         fm  = fm + st;
      end
      en_i = 1'b1;
      wait_until(s + (n - 1) * (d + 1));
      en_i = 1'b0;
      cycle();
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      // 1. Reset overrides enable and config valid
      rst_n_i     = 1'b0;
      en_i        = 1'b1;
      cfg_valid_i = 1'b1;
      ftw_i       = 25'h123;
      poff_i      = 25'h45;
      div_i       = 8'd2;
      step_i      = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_w("rst_phase", phase_o, 25'h0);
      check_b("rst_valid", phase_valid_o, 1'b0);
      check_b("rst_wrap", wrap_o, 1'b0);
      check_b("rst_ready", cfg_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_n_i     = 1'b1;
      en_i        = 1'b0;
      cfg_valid_i = 1'b0;
      check_b("post_rst_ready", cfg_ready_o, 1'b1);
      cycle();
      check_b("post_rst_ready2", cfg_ready_o, 1'b1);
      check_w("post_rst_phase", phase_o, 25'h0);

      // 2. div=0, full-range sweep with accumulator wrap at sample 31
      do_cfg(25'h100000, 25'h0, 8'd0, 25'h0);
      burst(33, 25'h100000, 25'h0, 0, 25'h0);

      // 3. div=3, one strobe in four
      do_cfg(25'h10, 25'h0, 8'd3, 25'h0);
      burst(4, 25'h10, 25'h0, 3, 25'h0);

      // 4. Mid-interval reconfig: applying tick still advances by 0x10
      s = cyc + 5;
      push(25'h00, 1'b0, s);
      push(25'h10, 1'b0, s + 4);
      push(25'h20, 1'b0, s + 8);
      push(25'h60, 1'b0, s + 12);
      push(25'hA0, 1'b0, s + 16);
      en_i = 1'b1;
      wait_until(s + 1);
      cfg_valid_i = 1'b1;
      ftw_i  = 25'h40;
      poff_i = 25'h0;
      div_i  = 8'd3;
      cycle();
      cfg_valid_i = 1'b0;
      check_b("t4_ready_wait1", cfg_ready_o, 1'b0);
      cycle();
      check_b("t4_ready_wait2", cfg_ready_o, 1'b0);
      cycle();
      check_b("t4_ready_after_tick", cfg_ready_o, 1'b1);
      wait_until(s + 16);
      en_i = 1'b0;
      cycle();
      cycle();

      // 5. Offset wrap does not raise wrap_o; restart after en drop
      do_cfg(25'h1, 25'h1FFFFFF, 8'd0, 25'h0);
      burst(2, 25'h1, 25'h1FFFFFF, 0, 25'h0);
      check_w("idle_hold_phase", phase_o, 25'h0);
      check_b("idle_no_valid", phase_valid_o, 1'b0);
      burst(1, 25'h1, 25'h1FFFFFF, 0, 25'h0);
      check_w("idle_hold_phase2", phase_o, 25'h1FFFFFF);

      // ftw=0: constant phase = poff, div=1
      do_cfg(25'h0, 25'h55, 8'd1, 25'h0);
      burst(3, 25'h0, 25'h55, 1, 25'h0);

`ifdef DDS_PHASE_SWEEP_EN
      // 6. Linear chirp, positive then negative step
      do_cfg(25'h100, 25'h0, 8'd0, 25'h10);
      burst(4, 25'h100, 25'h0, 0, 25'h10);
      do_cfg(25'h100, 25'h0, 8'd0, 25'h1FFFFF0);
      burst(4, 25'h100, 25'h0, 0, 25'h1FFFFF0);
`endif

      for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL missing_strobes: got %0d outstanding, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
